// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_flags
// Purpose  : Single-clock FIFO using MSB-extended read/write pointers. Provides
//            an occupancy count, programmable almost_full/almost_empty
//            thresholds and a selectable read mode (registered or
//            first-word-fall-through).
// Ports    :
//   clk          - clock; all state updates on the rising edge
//   rst_n        - synchronous, active-low reset (priority over all activity)
//   w_en         - write request
//   data_in      - write data [DATA_WIDTH]
//   r_en         - read request (FWFT=1: pop/acknowledge the head entry)
//   data_out     - read data [DATA_WIDTH]
//   full         - count == DEPTH
//   empty        - count == 0
//   almost_full  - count >= AF_LEVEL
//   almost_empty - count <= AE_LEVEL
//   count        - stored entries, 0..DEPTH [PTR_WIDTH+1]
//   overflow     - sticky, write attempted while full   (SYNC_FIFO_ERR_FLAGS_EN)
//   underflow    - sticky, read attempted while empty   (SYNC_FIFO_ERR_FLAGS_EN)
// Options  : define SYNC_FIFO_ERR_FLAGS_EN to add the overflow/underflow ports.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_flags #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [PTR_WIDTH:0] c_af_level = (PTR_WIDTH+1)'(AF_LEVEL);
    localparam logic [PTR_WIDTH:0] c_ae_level = (PTR_WIDTH+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH:0]    r_w_ptr;
    logic [PTR_WIDTH:0]    r_r_ptr;

    logic [PTR_WIDTH:0]    w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_accept;
    logic                  w_rd_accept;

    // All flags come from registered pointers only, so no path from the
    // request inputs reaches them.
    assign w_count = r_w_ptr - r_r_ptr;
    assign w_full  = (r_w_ptr[PTR_WIDTH] != r_r_ptr[PTR_WIDTH]) &&
                     (r_w_ptr[PTR_WIDTH-1:0] == r_r_ptr[PTR_WIDTH-1:0]);
    assign w_empty = (r_w_ptr == r_r_ptr);

    assign w_wr_accept = w_en && !w_full;
    assign w_rd_accept = r_en && !w_empty;

    assign count        = w_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (w_count >= c_af_level);
    assign almost_empty = (w_count <= c_ae_level);

    // Pointer update; the MSB toggles on each wrap of the address bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w_ptr <= '0;
            r_r_ptr <= '0;
        end else begin
            if (w_wr_accept) begin
                r_w_ptr <= r_w_ptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_r_ptr <= r_r_ptr + 1'b1;
            end
        end
    end

    // Storage array is deliberately not reset. A write cycle coinciding with
    // reset is gated so the discarded entry never lands in memory.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_accept) begin
            r_mem[r_w_ptr[PTR_WIDTH-1:0]] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is presented directly; zero while nothing is stored.
            assign data_out = w_empty ? '0 : r_mem[r_r_ptr[PTR_WIDTH-1:0]];
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_data_out;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_data_out <= '0;
                end else if (w_rd_accept) begin
                    r_data_out <= r_mem[r_r_ptr[PTR_WIDTH-1:0]];
                end
            end

            assign data_out = r_data_out;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (r_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised single-clock FIFO with MSB-extended read/write pointers.
- Adds an occupancy count, programmable almost_full/almost_empty thresholds and a selectable first-word-fall-through (FWFT) read mode.
- Drop-in buffer between streaming producer/consumer blocks in the same clock domain.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2.
- DATA_WIDTH, 8, width of each entry in bits.
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- PTR_WIDTH, $clog2(DEPTH), derived; not to be overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- w_en  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- r_en  input  1  read request (FWFT=1: pop/acknowledge of the head entry).
- data_out  output  DATA_WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  PTR_WIDTH+1  current number of stored entries, 0..DEPTH.
- overflow  output  1  sticky error flag; present only with SYNC_FIFO_ERR_FLAGS_EN.
- underflow  output  1  sticky error flag; present only with SYNC_FIFO_ERR_FLAGS_EN.

Behaviour:
- Reset
  - Reset is clk, with rst_n synchronous and active-low; it has priority over all other activity.
  - On reset: w_ptr=0, r_ptr=0, data_out=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored entries on that edge. Any w_en/r_en in the same cycle is ignored.
- Pointers and flags
  - w_ptr and r_ptr are PTR_WIDTH+1 bits. The low PTR_WIDTH bits address memory; the MSB toggles on each wrap.
  - count = (w_ptr - r_ptr) modulo 2^(PTR_WIDTH+1).
  - All flags are derived from registered pointers only, so they are glitch-free and carry no combinational path from w_en/r_en.
  - full: MSBs differ and low bits are equal.
  - empty: pointers are fully equal.
- Write acceptance
  - A write is accepted when w_en && !full, using the full value before the edge.
  - On an accepted write, data_in is stored at w_ptr and w_ptr increments.
- Read acceptance
  - A read is accepted when r_en && !empty, using the empty value before the edge.
  - On an accepted read, r_ptr increments.
- Simultaneous w_en and r_en
  - Neither full nor empty: both accepted; count unchanged.
  - When full: read accepted, write dropped; count decrements.
  - When empty: write accepted, read dropped; count increments.
- FWFT=0 (registered read)
  - data_out updates on the edge of an accepted read with mem[r_ptr], giving 1-cycle latency.
  - Otherwise data_out holds its value.
- FWFT=1
  - data_out = mem[r_ptr[PTR_WIDTH-1:0]] whenever !empty; data_out = 0 when empty.
  - A write into an empty FIFO is visible on data_out and empty deasserts in the cycle after the write edge.
  - An accepted r_en presents the next entry in the following cycle.
- Wrap-around
  - Pointers wrap naturally at 2^(PTR_WIDTH+1); ordering is preserved across any number of wraps.
- Rejected requests
  - A rejected write or read changes no state except the optional sticky flags.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- Defined
  - Adds the overflow and underflow output ports, both reset to 0.
  - overflow sets on any edge with w_en && full and the write is rejected.
  - underflow sets on any edge with r_en && empty.
  - Both flags stay set until reset.
- Undefined: the ports and their logic are absent; rejected requests are silently ignored.

Test Plan:
- Directed scenarios use DEPTH=8, DATA_WIDTH=8, AF_LEVEL=6, AE_LEVEL=2.
- Reset then idle -> count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_out=0.
- Write 0x01..0x08 on consecutive cycles:
  - almost_empty deasserts after the 3rd write.
  - almost_full asserts after the 6th write.
  - full=1 and count=8 after the 8th write.
  - A 9th write of 0xFF is dropped (overflow=1 with SYNC_FIFO_ERR_FLAGS_EN).
- FWFT=0, read 8 times from full:
  - data_out = 0x01..0x08, each one cycle after its r_en.
  - empty=1 after the last read.
  - A further r_en leaves data_out=0x08 (underflow=1 with the macro).
- Fill to 4, then assert w_en and r_en together for 20 cycles with incrementing data -> count stays 4, pointers wrap at least twice, output order matches input order.
- Full FIFO with w_en=r_en=1 -> count goes 8→7, the oldest entry is read, data_in is not stored.
- Empty FIFO with w_en=r_en=1 -> count goes 0→1.
- FWFT=1:
  - Write 0xA5 into empty -> next cycle empty=0 and data_out=0xA5 with no r_en.
  - An r_en pulse -> empty=1 and data_out=0.
- rst_n low for one cycle with count=5 and w_en=1 -> count=0, empty=1, write discarded, sticky flags cleared.
